// File: rtl/gppcu_host_sequencer.sv
// rtl/gppcu_host_sequencer.sv - two-requester round-robin command sequencer for the GPPCU iCMD/iDATA port
// Generates the setup/strobe/hold waveform per granted request and tracks instruction-queue occupancy.
module gppcu_host_sequencer #(
    parameter int SETUP_CYC = 1,
    parameter int HIGH_CYC  = 2,
    parameter int HOLD_CYC  = 1,
    parameter int QCAP      = 127
) (
    input  logic        iACLK,
    input  logic        iRST,
    input  logic        iR0_VALID,
    output logic        oR0_READY,
    input  logic [6:0]  iR0_OP,
    input  logic [7:0]  iR0_SEL,
    input  logic [15:0] iR0_ADDR,
    input  logic [31:0] iR0_WDATA,
    input  logic        iR1_VALID,
    output logic        oR1_READY,
    input  logic [6:0]  iR1_OP,
    input  logic [7:0]  iR1_SEL,
    input  logic [15:0] iR1_ADDR,
    input  logic [31:0] iR1_WDATA,
    output logic        oRSP_VALID,
    output logic        oRSP_ID,
    output logic        oRSP_ERR,
    output logic [31:0] oRSP_DATA,
    output logic [31:0] oCMD,
    output logic [31:0] oDATA,
    input  logic [31:0] iDATA,
    input  logic        iINSTR_POP,
    output logic [7:0]  oQ_LEVEL
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RESP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  cnt;
    logic        rr_ptr;
    logic [6:0]  op_q;
    logic [7:0]  sel_q;
    logic [15:0] addr_q;
    logic [31:0] wdata_q;
    logic        id_q;
    logic        err_q;
    logic [31:0] rsp_data_q;
    logic [7:0]  level;

    logic        elig0;
    logic        elig1;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [6:0]  acc_op;
    logic [7:0]  acc_sel;
    logic [15:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        last_setup;
    logic        last_strobe;
    logic        last_hold;
    logic        push;
    logic        pop_eff;

    // Instruction pushes are held back while the queue is full so it can never overflow.
    assign elig0 = iR0_VALID && ((iR0_OP != 7'd0) || (level < 8'(QCAP)));
    assign elig1 = iR1_VALID && ((iR1_OP != 7'd0) || (level < 8'(QCAP)));

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && !iRST) begin
            grant0 = elig0 && (!elig1 || !rr_ptr);
            grant1 = elig1 && (!elig0 || rr_ptr);
        end
    end

    assign accept    = grant0 || grant1;
    assign oR0_READY = grant0;
    assign oR1_READY = grant1;

    assign acc_op    = grant1 ? iR1_OP    : iR0_OP;
    assign acc_sel   = grant1 ? iR1_SEL   : iR0_SEL;
    assign acc_addr  = grant1 ? iR1_ADDR  : iR0_ADDR;
    assign acc_wdata = grant1 ? iR1_WDATA : iR0_WDATA;

    assign last_setup  = (cnt == 8'(SETUP_CYC - 1));
    assign last_strobe = (cnt == 8'(HIGH_CYC - 1));
    assign last_hold   = (cnt == 8'(HOLD_CYC - 1));

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        oCMD       = 32'd0;
        oDATA      = 32'd0;
        oRSP_VALID = 1'b0;
        oRSP_ID    = 1'b0;
        oRSP_ERR   = 1'b0;
        oRSP_DATA  = 32'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (acc_op > 7'd3) ? RESP : SETUP;
                end
            end
            SETUP: begin
                oCMD  = {1'b0, op_q, sel_q, addr_q};
                oDATA = wdata_q;
                if (last_setup) begin
                    state_nxt = STROBE;
                end
            end
            STROBE: begin
                oCMD  = {1'b1, op_q, sel_q, addr_q};
                oDATA = wdata_q;
                if (last_strobe) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                oCMD  = {1'b0, op_q, sel_q, addr_q};
                oDATA = wdata_q;
                if (last_hold) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                oRSP_VALID = 1'b1;
                oRSP_ID    = id_q;
                oRSP_ERR   = err_q;
                oRSP_DATA  = rsp_data_q;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A push counts once the strobe is about to rise; a pop on an empty queue is dropped.
    assign push    = (state == SETUP) && last_setup && (op_q == 7'd0);
    assign pop_eff = iINSTR_POP && (level != 8'd0);

    always_ff @(posedge iACLK) begin
        if (iRST) begin
            cnt        <= 8'd0;
            rr_ptr     <= 1'b0;
            op_q       <= 7'd0;
            sel_q      <= 8'd0;
            addr_q     <= 16'd0;
            wdata_q    <= 32'd0;
            id_q       <= 1'b0;
            err_q      <= 1'b0;
            rsp_data_q <= 32'd0;
            level      <= 8'd0;
        end else begin
            if (state_nxt != state || state == IDLE) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
            if (accept) begin
                op_q       <= acc_op;
                sel_q      <= acc_sel;
                addr_q     <= acc_addr;
                wdata_q    <= acc_wdata;
                id_q       <= grant1;
                err_q      <= (acc_op > 7'd3);
                rsp_data_q <= 32'd0;
                rr_ptr     <= !grant1;
            end
            if (state == HOLD && last_hold) begin
                rsp_data_q <= (op_q == 7'd1) ? iDATA : 32'd0;
            end
            if (push && !pop_eff) begin
                level <= level + 8'd1;
            end else if (!push && pop_eff) begin
                level <= level - 8'd1;
            end
        end
    end

    assign oQ_LEVEL = level;

endmodule
